// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, default
// vector base and the lowest-index priority-encoder function.
package intr_pkg;

    // Handshake states of the request FSM.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACKW = 2'd2
    } state_t;

    // Widest source vector supported, and the index width that covers it.
    localparam int MAX_SRC = 32;
    localparam int IDX_W   = 5;

    // Vector presented for source 0 unless overridden.
    localparam logic [7:0] DEFAULT_BASE_VEC = 8'h20;

    // Index of the lowest set bit; 0 when no bit is set (qualify with |v).
    function automatic logic [IDX_W-1:0] lowest_set(input logic [MAX_SRC-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// Lowest-index-wins priority encoder with a valid flag.
module intr_prio_enc
    import intr_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [MAX_SRC-1:0] req_ext;

    assign req_ext = MAX_SRC'(req);
    assign idx     = lowest_set(req_ext);
    assign valid   = |req;

endmodule

// File: rtl/intr_ctrl.sv
// Prioritised interrupt controller: synchronises raw lines, tracks pending
// and in-service sources, and presents one vector at a time to the CPU
// through an intr/inta handshake with nested-priority support.
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int                 NUM_SRC   = 8,
    parameter int                 VEC_W     = 8,
    parameter logic [VEC_W-1:0]   BASE_VEC  = VEC_W'(DEFAULT_BASE_VEC),
    parameter logic [NUM_SRC-1:0] EDGE_MASK = '1
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    input  logic               eoi,
    input  logic               inta,
    output logic               intr,
    output logic [VEC_W-1:0]   vector,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] in_service
);

    logic [NUM_SRC-1:0] sync1_q, sync2_q, prev_q;
    logic [1:0]         prime_cnt_q;
    logic               primed;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] pend_edge_q;
    logic [NUM_SRC-1:0] mask_q;
    logic [NUM_SRC-1:0] is_q, is_d;
    logic [NUM_SRC-1:0] below, eligible;
    logic [NUM_SRC-1:0] ack_onehot, ack_clr, eoi_clr;
    logic [IDX_W-1:0]   cand_idx, is_idx;
    logic               cand_valid, is_valid;
    logic               ack;
    state_t             state_q, state_d;
    logic [IDX_W-1:0]   id_q, id_d;

    // Two-flop synchroniser plus edge-history flop; history is loaded from the
    // first stage until primed so lines already high at reset release never
    // look like a rising edge.
    // NOTE: every clocked block uses non-blocking assignments so all flops
    // sample the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            prime_cnt_q <= '0;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
            prev_q  <= primed ? sync2_q : sync1_q;
            if (!primed) prime_cnt_q <= prime_cnt_q + 2'd1;
        end
    end

    assign primed = (prime_cnt_q == 2'd2);
    assign rise   = sync2_q & ~prev_q & {NUM_SRC{primed}} & EDGE_MASK;

    // Acknowledge strobe and the one-hot of the source being acknowledged.
    assign ack        = (state_q == ST_REQ) && inta;
    assign ack_onehot = NUM_SRC'(1) << id_q;
    assign ack_clr    = ack ? ack_onehot : '0;

    // Edge-pending register: a new edge beats a simultaneous acknowledge clear.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) pend_edge_q <= '0;
        else     pend_edge_q <= ((pend_edge_q & ~ack_clr) | rise) & EDGE_MASK;
    end

    // Level sources mirror the synchronised line directly.
    assign pending = (pend_edge_q & EDGE_MASK) | (sync2_q & ~EDGE_MASK);

    // Mask register, fully masked out of reset.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)          mask_q <= '1;
        else if (mask_we) mask_q <= mask_wdata;
    end

    intr_prio_enc #(.N(NUM_SRC)) u_is_enc (
        .req   (is_q),
        .idx   (is_idx),
        .valid (is_valid)
    );

    // Only sources strictly above the highest-priority in-service one may nest.
    assign below    = is_valid ? ((NUM_SRC'(1) << is_idx) - NUM_SRC'(1)) : '1;
    assign eligible = pending & ~mask_q & below;

    intr_prio_enc #(.N(NUM_SRC)) u_cand_enc (
        .req   (eligible),
        .idx   (cand_idx),
        .valid (cand_valid)
    );

    // In-service update: EOI clear first, then acknowledge set, so set wins.
    // NOTE: combinational blocks assign every output a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        eoi_clr = (eoi && is_valid) ? (NUM_SRC'(1) << is_idx) : '0;
        is_d    = (is_q & ~eoi_clr) | ack_clr;
    end

    // In-service register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) is_q <= '0;
        else     is_q <= is_d;
    end

    assign in_service = is_q;

    // FSM state and latched source id.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
        end
    end

    // FSM next state and outputs; id is frozen outside IDLE.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        intr    = 1'b0;
        vector  = '0;
        case (state_q)
            ST_IDLE: begin
                if (cand_valid) begin
                    id_d    = cand_idx;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                intr   = 1'b1;
                vector = BASE_VEC + VEC_W'(id_q);
                if (inta) state_d = ST_ACKW;
            end
            ST_ACKW: begin
                vector = BASE_VEC + VEC_W'(id_q);
                if (!inta) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed self-checking bench for intr_ctrl (source 0 level, others edge).
module tb_intr_ctrl;

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] irq_in;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic       eoi;
    logic       inta;
    logic       intr;
    logic [7:0] vector;
    logic [7:0] pending;
    logic [7:0] in_service;

    int errors = 0;
    int checks = 0;

    intr_ctrl #(
        .NUM_SRC   (8),
        .VEC_W     (8),
        .BASE_VEC  (8'h20),
        .EDGE_MASK (8'hFE)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .eoi        (eoi),
        .inta       (inta),
        .intr       (intr),
        .vector     (vector),
        .pending    (pending),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        clr = 1'b1; irq_in = '0; mask_we = 1'b0; mask_wdata = '0; eoi = 1'b0; inta = 1'b0;
        tick(); tick();
        clr = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic set_mask(input logic [7:0] m);
        mask_wdata = m; mask_we = 1'b1;
        tick();
        mask_we = 1'b0;
    endtask

    task automatic pulse_irq(input int src);
        irq_in[src] = 1'b1;
        tick();
        irq_in[src] = 1'b0;
    endtask

    task automatic do_ack();
        inta = 1'b1;
        tick();
        inta = 1'b0;
        tick();
    endtask

    task automatic eoi_pulse();
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
    endtask

    task automatic wait_intr(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= budget; i++) begin
            if (intr === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (i < budget) tick();
        end
    endtask

    task automatic test_reset();
        bit ok;
        clr = 1'b1; irq_in = 8'h08; mask_we = 1'b0; mask_wdata = '0; eoi = 1'b0; inta = 1'b0;
        #1;
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL rst_intr: got %b want 0", intr); end
        checks++; if (vector !== 8'h00) begin errors++; $display("FAIL rst_vector: got %h want 00", vector); end
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL rst_pending: got %h want 00", pending); end
        checks++; if (in_service !== 8'h00) begin errors++; $display("FAIL rst_in_service: got %h want 00", in_service); end
        tick(); tick();
        clr = 1'b0;
        set_mask(8'h00);
        repeat (8) tick();
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL rst_no_false_edge_intr: got %b want 0", intr); end
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL rst_no_false_edge_pend: got %h want 00", pending); end
        irq_in = '0;
        repeat (3) tick();
        pulse_irq(3);
        wait_intr(8, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_real_edge: got no intr want intr"); end
    endtask

    task automatic test_basic();
        do_reset();
        set_mask(8'h00);
        irq_in[3] = 1'b1;
        for (int i = 0; i < 4 && intr !== 1'b1; i++) tick();
        checks++; if (intr !== 1'b1) begin errors++; $display("FAIL basic_intr_latency: got %b want 1 within 4 cycles", intr); end
        checks++; if (vector !== 8'h23) begin errors++; $display("FAIL basic_vector: got %h want 23", vector); end
        irq_in[3] = 1'b0;
        inta = 1'b1;
        tick();
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL basic_ack_intr: got %b want 0", intr); end
        checks++; if (in_service !== 8'h08) begin errors++; $display("FAIL basic_in_service: got %h want 08", in_service); end
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL basic_pending_cleared: got %h want 00", pending); end
        checks++; if (vector !== 8'h23) begin errors++; $display("FAIL basic_ackw_vector: got %h want 23", vector); end
        inta = 1'b0;
        tick();
        checks++; if (vector !== 8'h00) begin errors++; $display("FAIL basic_idle_vector: got %h want 00", vector); end
    endtask

    task automatic test_priority();
        bit ok;
        do_reset();
        set_mask(8'h00);
        irq_in = 8'h24;
        tick();
        irq_in = 8'h00;
        wait_intr(8, ok);
        checks++; if (!ok) begin errors++; $display("FAIL prio_first_intr: got no intr want intr"); end
        checks++; if (vector !== 8'h22) begin errors++; $display("FAIL prio_first_vector: got %h want 22", vector); end
        set_mask(8'hFF);
        tick();
        checks++; if (intr !== 1'b1 || vector !== 8'h22) begin errors++; $display("FAIL prio_frozen: got intr=%b vec=%h want intr=1 vec=22", intr, vector); end
        set_mask(8'h00);
        inta = 1'b1;
        tick();
        checks++; if (in_service !== 8'h04) begin errors++; $display("FAIL prio_in_service: got %h want 04", in_service); end
        inta = 1'b0;
        tick(); tick();
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL prio_blocked: got %b want 0", intr); end
        eoi_pulse();
        wait_intr(8, ok);
        checks++; if (!ok || vector !== 8'h25) begin errors++; $display("FAIL prio_second_vector: got ok=%b vec=%h want ok=1 vec=25", ok, vector); end
        do_ack();
        eoi_pulse();
    endtask

    task automatic test_nested();
        bit ok;
        do_reset();
        set_mask(8'h00);
        pulse_irq(4);
        wait_intr(8, ok);
        checks++; if (!ok || vector !== 8'h24) begin errors++; $display("FAIL nest_src4: got ok=%b vec=%h want ok=1 vec=24", ok, vector); end
        do_ack();
        checks++; if (in_service !== 8'h10) begin errors++; $display("FAIL nest_is4: got %h want 10", in_service); end
        pulse_irq(1);
        wait_intr(8, ok);
        checks++; if (!ok || vector !== 8'h21) begin errors++; $display("FAIL nest_src1: got ok=%b vec=%h want ok=1 vec=21", ok, vector); end
        do_ack();
        checks++; if (in_service !== 8'h12) begin errors++; $display("FAIL nest_is41: got %h want 12", in_service); end
        pulse_irq(6);
        repeat (6) tick();
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL nest_src6_blocked1: got %b want 0", intr); end
        eoi_pulse();
        checks++; if (in_service !== 8'h10) begin errors++; $display("FAIL nest_eoi1: got %h want 10", in_service); end
        repeat (4) tick();
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL nest_src6_blocked2: got %b want 0", intr); end
        eoi_pulse();
        checks++; if (in_service !== 8'h00) begin errors++; $display("FAIL nest_eoi2: got %h want 00", in_service); end
        wait_intr(8, ok);
        checks++; if (!ok || vector !== 8'h26) begin errors++; $display("FAIL nest_src6: got ok=%b vec=%h want ok=1 vec=26", ok, vector); end
        do_ack();
        eoi_pulse();
    endtask

    task automatic test_level();
        bit ok;
        do_reset();
        set_mask(8'h00);
        irq_in[0] = 1'b1;
        wait_intr(8, ok);
        checks++; if (!ok || vector !== 8'h20) begin errors++; $display("FAIL lvl_first: got ok=%b vec=%h want ok=1 vec=20", ok, vector); end
        do_ack();
        checks++; if (in_service !== 8'h01 || pending !== 8'h01) begin errors++; $display("FAIL lvl_after_ack: got is=%h pend=%h want is=01 pend=01", in_service, pending); end
        tick(); tick();
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL lvl_blocked: got %b want 0", intr); end
        eoi_pulse();
        wait_intr(8, ok);
        checks++; if (!ok || vector !== 8'h20) begin errors++; $display("FAIL lvl_rerequest: got ok=%b vec=%h want ok=1 vec=20", ok, vector); end
        do_ack();
        set_mask(8'h01);
        eoi_pulse();
        repeat (6) tick();
        checks++; if (intr !== 1'b0 || pending !== 8'h01) begin errors++; $display("FAIL lvl_masked: got intr=%b pend=%h want intr=0 pend=01", intr, pending); end
        irq_in[0] = 1'b0;
    endtask

    task automatic test_clr_mid();
        bit ok;
        do_reset();
        set_mask(8'h00);
        pulse_irq(3);
        wait_intr(8, ok);
        checks++; if (!ok) begin errors++; $display("FAIL clr_setup: got no intr want intr"); end
        #2;
        clr = 1'b1;
        inta = 1'b1;
        #1;
        checks++; if (intr !== 1'b0 || vector !== 8'h00) begin errors++; $display("FAIL clr_async: got intr=%b vec=%h want intr=0 vec=00", intr, vector); end
        checks++; if (pending !== 8'h00 || in_service !== 8'h00) begin errors++; $display("FAIL clr_regs: got pend=%h is=%h want 00 00", pending, in_service); end
        tick(); tick();
        clr = 1'b0;
        inta = 1'b0;
        repeat (3) tick();
        checks++; if (in_service !== 8'h00) begin errors++; $display("FAIL clr_no_ack: got %h want 00", in_service); end
        pulse_irq(3);
        repeat (8) tick();
        checks++; if (intr !== 1'b0 || pending !== 8'h08) begin errors++; $display("FAIL clr_mask_ones: got intr=%b pend=%h want intr=0 pend=08", intr, pending); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_reset();
        set_mask(8'h00);
        pulse_irq(2);
        wait_intr(8, ok);
        checks++; if (!ok || vector !== 8'h22) begin errors++; $display("FAIL b2b_first: got ok=%b vec=%h want ok=1 vec=22", ok, vector); end
        repeat (3) tick();
        irq_in[2] = 1'b1;
        tick(); tick();
        inta = 1'b1;
        tick();
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL b2b_ack_intr: got %b want 0", intr); end
        checks++; if (pending[2] !== 1'b1) begin errors++; $display("FAIL b2b_pending_kept: got %b want 1", pending[2]); end
        checks++; if (in_service !== 8'h04) begin errors++; $display("FAIL b2b_in_service: got %h want 04", in_service); end
        inta = 1'b0;
        irq_in[2] = 1'b0;
        tick(); tick();
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL b2b_blocked: got %b want 0", intr); end
        eoi_pulse();
        wait_intr(8, ok);
        checks++; if (!ok || vector !== 8'h22) begin errors++; $display("FAIL b2b_second: got ok=%b vec=%h want ok=1 vec=22", ok, vector); end
        do_ack();
        eoi_pulse();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_nested();
        test_level();
        test_clr_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
